// File: rtl/guess_responder.sv
// guess_responder: MCU-side end of the guess/timing protocol.
// Announces BEGIN_GUESSING after arm, receives START + CODE_LEN guess bytes + END,
// compares against the latched secret one byte per CMP_CYCLES cycles with early
// exit, then replies YES or NO. Reply latency leaks the matching-prefix length.
// Ports:
//   CLK_50, RST_N             clock, async active-low reset
//   arm                       session start pulse (honoured only in IDLE)
//   secret                    secret bytes, byte i at [8i+7:8i], latched on arm
//   rx_valid, rx_data         received byte strobe and data
//   tx_valid, tx_data,
//   tx_ready                  transmit handshake towards the byte PHY
//   busy                      high whenever not IDLE
//   unlocked                  sticky after YES, cleared by next arm
//   attempt_count             replies sent this session, saturating
//   rx_drop                   pulse when an rx byte arrives where it cannot be used
module guess_responder #(
  parameter int CODE_LEN   = 16,
  parameter int CMP_CYCLES = 4,
  parameter int ATTEMPT_W  = 16
) (
  input  logic                    CLK_50,
  input  logic                    RST_N,
  input  logic                    arm,
  input  logic [8*CODE_LEN-1:0]   secret,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    unlocked,
  output logic [ATTEMPT_W-1:0]    attempt_count,
  output logic                    rx_drop
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int CNT_W = (CMP_CYCLES > 1) ? $clog2(CMP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_CYCLES - 1);

  localparam logic [7:0] B_START = 8'h01;
  localparam logic [7:0] B_BEGIN = 8'h02;
  localparam logic [7:0] B_YES   = 8'h03;
  localparam logic [7:0] B_NO    = 8'h04;
  localparam logic [7:0] B_END   = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_ANNOUNCE, S_WAIT_START, S_RECV, S_WAIT_END, S_COMPARE, S_REPLY
  } state_t;

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [IDX_W-1:0]     i_q, i_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 yes_q, yes_n;
  logic                 unl_n;
  logic [ATTEMPT_W-1:0] att_n;
  logic                 latch, store, drop_n;
  logic [7:0]           tx_data_n;
  logic [7:0]           sec_q   [CODE_LEN];
  logic [7:0]           guess_q [CODE_LEN];
  logic [1:0]           rst_sync;
  logic                 rst_n_i;

  // Assert asynchronously, release on the clock so all state leaves reset together.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    i_n     = i_q;
    cnt_n   = cnt_q;
    yes_n   = yes_q;
    unl_n   = unlocked;
    att_n   = attempt_count;
    latch   = 1'b0;
    store   = 1'b0;
    drop_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          latch   = 1'b1;
          unl_n   = 1'b0;
          att_n   = '0;
          state_n = S_ANNOUNCE;
        end
      end
      S_ANNOUNCE: begin
        drop_n = rx_valid;
        if (tx_ready) state_n = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (rx_valid && rx_data == B_START) begin
          idx_n   = '0;
          state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          store = 1'b1;
          if (idx_q == IDX_LAST) state_n = S_WAIT_END;
          else                   idx_n   = idx_q + 1'b1;
        end
      end
      S_WAIT_END: begin
        if (rx_valid) begin
          if (rx_data == B_END) begin
            i_n     = '0;
            cnt_n   = '0;
            state_n = S_COMPARE;
          end else begin
            yes_n   = 1'b0;
            state_n = S_REPLY;
          end
        end
      end
      S_COMPARE: begin
        drop_n = rx_valid;
        if (cnt_q == CNT_LAST) begin
          if (guess_q[i_q] != sec_q[i_q]) begin
            yes_n   = 1'b0;
            state_n = S_REPLY;
          end else if (i_q == IDX_LAST) begin
            yes_n   = 1'b1;
            state_n = S_REPLY;
          end else begin
            i_n   = i_q + 1'b1;
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_REPLY: begin
        drop_n = rx_valid;
        if (tx_ready) begin
          if (!(&attempt_count)) att_n = attempt_count + 1'b1;
          if (yes_q) begin
            unl_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    tx_data_n = 8'h00;
    if (state_n == S_ANNOUNCE)   tx_data_n = B_BEGIN;
    else if (state_n == S_REPLY) tx_data_n = yes_n ? B_YES : B_NO;
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK_50 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      i_q           <= '0;
      cnt_q         <= '0;
      yes_q         <= 1'b0;
      unlocked      <= 1'b0;
      attempt_count <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      busy          <= 1'b0;
      rx_drop       <= 1'b0;
      for (int unsigned b = 0; b < CODE_LEN; b++) sec_q[b] <= '0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      i_q           <= i_n;
      cnt_q         <= cnt_n;
      yes_q         <= yes_n;
      unlocked      <= unl_n;
      attempt_count <= att_n;
      tx_valid      <= (state_n == S_ANNOUNCE) || (state_n == S_REPLY);
      tx_data       <= tx_data_n;
      busy          <= (state_n != S_IDLE);
      rx_drop       <= drop_n;
      if (latch) begin
        for (int unsigned b = 0; b < CODE_LEN; b++) sec_q[b] <= secret[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (store) guess_q[idx_q] <= rx_data;
  end

endmodule

// File: tb/tb_guess_responder.sv
module tb_guess_responder;
  localparam int CL = 4;
  localparam int CC = 4;

  logic          CLK_50 = 1'b0;
  logic          RST_N = 1'b0;
  logic          arm = 1'b0;
  logic [8*CL-1:0] secret = 32'h40302010;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          unlocked;
  logic [15:0]   attempt_count;
  logic          rx_drop;

  guess_responder #(.CODE_LEN(CL), .CMP_CYCLES(CC), .ATTEMPT_W(16)) dut (
    .CLK_50(CLK_50), .RST_N(RST_N), .arm(arm), .secret(secret),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .unlocked(unlocked),
    .attempt_count(attempt_count), .rx_drop(rx_drop)
  );

  always #5 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  // Monitor: records every new tx byte (data + cycle), counts rx_drop pulses,
  // and flags any change of tx_data while a byte is pending.
  logic [7:0] obs_d [256];
  int         obs_c [256];
  int         obs_wr = 0;
  int         stab_err = 0;
  int         drop_cnt = 0;
  logic       pv = 1'b0, phs = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge CLK_50) begin
    if (!RST_N) begin
      pv = 1'b0;
      phs = 1'b0;
    end else begin
      if (tx_valid && (!pv || phs)) begin
        obs_d[obs_wr % 256] = tx_data;
        obs_c[obs_wr % 256] = cyc;
        obs_wr++;
      end else if (tx_valid && tx_data != pd) begin
        stab_err++;
      end
      if (rx_drop) drop_cnt++;
      pv  = tx_valid;
      pd  = tx_data;
      phs = tx_valid && tx_ready;
    end
  end

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t exp_q[$];
  int   obs_rd = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       arm_first;
    logic [7:0] g [4];
    logic [7:0] endb;
    logic [7:0] rep;
    int         lat;
    logic       unl;
    int         att;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string nm);
    int   n;
    exp_t e;
    n = 0;
    while (obs_rd == obs_wr && n < 100) begin
      step();
      n++;
    end
    if (obs_rd == obs_wr) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_tx"}, {24'd0, obs_d[obs_rd % 256]}, 32'hFFFF_FFFF);
      obs_rd++;
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_data"}, {24'd0, obs_d[obs_rd % 256]}, {24'd0, e.d});
      chk({nm, "_cycle"}, obs_c[obs_rd % 256], e.c);
      obs_rd++;
    end
  endtask

  task automatic do_arm(input string nm);
    exp_q.push_back('{8'h02, cyc + 1});
    arm = 1'b1;
    step();
    arm = 1'b0;
    wait_tx(nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, "_unlocked"}, {31'd0, unlocked}, 32'd0);
    chk({nm, "_attempts"}, {16'd0, attempt_count}, 32'd0);
  endtask

  task automatic guess(input string nm, input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3, input logic [7:0] eb,
                       input logic [7:0] rep, input int lat);
    send(8'h01);
    send(g0); send(g1); send(g2); send(g3);
    exp_q.push_back('{rep, cyc + lat});
    send(eb);
    wait_tx(nm);
  endtask

  initial begin
    int d0;
    tbl[0] = '{1'b0, '{8'h10, 8'h20, 8'h99, 8'h40}, 8'h05, 8'h04, 13, 1'b0, 1};
    tbl[1] = '{1'b0, '{8'h10, 8'h20, 8'h30, 8'h40}, 8'h05, 8'h03, 17, 1'b1, 2};
    tbl[2] = '{1'b1, '{8'h77, 8'h20, 8'h30, 8'h40}, 8'h05, 8'h04,  5, 1'b0, 1};
    tbl[3] = '{1'b0, '{8'h10, 8'h20, 8'h30, 8'h40}, 8'hAA, 8'h04,  1, 1'b0, 2};
    tbl[4] = '{1'b0, '{8'h01, 8'h02, 8'h03, 8'h04}, 8'h05, 8'h04,  5, 1'b0, 3};
    tbl[5] = '{1'b0, '{8'h10, 8'h20, 8'h30, 8'h05}, 8'h05, 8'h04, 17, 1'b0, 4};
    tbl[6] = '{1'b0, '{8'h10, 8'h20, 8'h30, 8'h40}, 8'h05, 8'h03, 17, 1'b1, 5};

    repeat (3) step();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
    chk("rst_attempts", {16'd0, attempt_count}, 32'd0);
    chk("rst_rx_drop", {31'd0, rx_drop}, 32'd0);
    RST_N = 1'b1;
    repeat (3) step();

    do_arm("arm0");

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].arm_first) do_arm($sformatf("arm_v%0d", v));
      guess($sformatf("vec%0d", v), tbl[v].g[0], tbl[v].g[1], tbl[v].g[2], tbl[v].g[3],
            tbl[v].endb, tbl[v].rep, tbl[v].lat);
      chk($sformatf("vec%0d_attempts", v), {16'd0, attempt_count}, tbl[v].att);
      chk($sformatf("vec%0d_unlocked", v), {31'd0, unlocked}, {31'd0, tbl[v].unl});
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, {31'd0, (tbl[v].rep != 8'h03)});
    end
    chk("table_no_drops", drop_cnt, 0);

    // tx_ready stall during NO, with an rx byte injected mid-stall and one coincident
    // with the handshake; a stray arm and a non-START byte in WAIT_START are ignored.
    do_arm("arm_stall");
    arm = 1'b1;
    step();
    arm = 1'b0;
    send(8'h55);
    d0 = drop_cnt;
    step();
    chk("wait_start_no_drop", drop_cnt, d0);
    tx_ready = 1'b0;
    guess("stall_no", 8'h77, 8'h20, 8'h30, 8'h40, 8'h05, 8'h04, 5);
    repeat (2) step();
    send(8'h33);
    repeat (6) step();
    chk("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("stall_tx_data", {24'd0, tx_data}, 32'h04);
    chk("stall_drop_once", drop_cnt, d0 + 1);
    chk("stall_attempts", {16'd0, attempt_count}, 32'd0);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    step();
    rx_valid = 1'b0;
    chk("stall_hs_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("stall_hs_attempts", {16'd0, attempt_count}, 32'd1);
    chk("stall_hs_busy", {31'd0, busy}, 32'd1);
    step();
    chk("coincident_drop", drop_cnt, d0 + 2);
    guess("after_stall_yes", 8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h03, 17);
    chk("after_stall_attempts", {16'd0, attempt_count}, 32'd2);
    chk("after_stall_unlocked", {31'd0, unlocked}, 32'd1);

    // Reset in the middle of COMPARE aborts the reply.
    do_arm("arm_rst");
    send(8'h01);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'h05);
    repeat (3) step();
    RST_N = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    repeat (2) step();
    RST_N = 1'b1;
    repeat (20) step();
    chk("midrst_no_reply", obs_wr - obs_rd, 0);
    do_arm("arm_post_rst");
    guess("post_rst_yes", 8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h03, 17);
    chk("post_rst_unlocked", {31'd0, unlocked}, 32'd1);
    chk("post_rst_attempts", {16'd0, attempt_count}, 32'd1);

    repeat (3) step();
    chk("tx_data_stable", stab_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("no_extra_tx", obs_wr - obs_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/guess_responder.md
# guess_responder

Responder (MCU-side) end of the guess/timing protocol. It announces readiness with BEGIN_GUESSING, collects a framed guess of CODE_LEN bytes, and compares it byte-by-byte against a secret with early exit. It replies YES or NO after a delay proportional to the number of leading matching bytes. It sits behind the CM bus byte PHY and provides a deterministic, cycle-exact timing-leak target for the attacker logic.

## Interface
Parameters:
- CODE_LEN, 16, secret/guess length in bytes (≥1)
- CMP_CYCLES, 4, cycles spent per compared byte (≥1)
- ATTEMPT_W, 16, width of attempt counter

Ports:
- CLK_50 in 1: sole clock, all logic on rising edge
- RST_N in 1: reset, asynchronous, active-low
- arm in 1: one-cycle pulse; starts a session; ignored unless in IDLE
- secret in 8*CODE_LEN: secret; byte i = secret[8i+7:8i]; sampled into an internal register on the accepted arm cycle
- rx_valid in 1: one-cycle strobe, received byte valid
- rx_data in 8: received byte
- tx_valid out 1: transmit byte valid
- tx_data out 8: transmit byte
- tx_ready in 1: PHY accepts byte when tx_valid && tx_ready
- busy out 1: high in any state except IDLE
- unlocked out 1: sticky high after a YES; cleared by the next accepted arm
- attempt_count out ATTEMPT_W: number of completed guesses (YES or NO sent) this session; saturates at all-ones
- rx_drop out 1: one-cycle pulse when an rx byte arrives in a state that cannot accept it

## Operation
Protocol bytes: START=0x01, BEGIN_GUESSING=0x02, YES=0x03, NO=0x04, END=0x05.

States:
- IDLE: on arm, latch secret, clear unlocked and attempt_count, go to ANNOUNCE.
- ANNOUNCE: tx_valid=1, tx_data=0x02; on handshake, go to WAIT_START.
- WAIT_START: rx 0x01 → RECV with idx=0; any other rx byte is silently ignored (no drop pulse).
- RECV: each rx byte is stored to buf[idx] and idx increments; after storing byte CODE_LEN-1, go to WAIT_END. Byte values are not interpreted, so 0x01–0x05 are legal guess bytes.
- WAIT_END: rx 0x05 → COMPARE with i=0 and cnt=0. Any other byte is a framing error → REPLY with NO, no compare delay.
- COMPARE: cnt counts 0..CMP_CYCLES-1 for index i. When cnt==CMP_CYCLES-1:
  - buf[i]≠secret[i] → REPLY NO.
  - else if i==CODE_LEN-1 → REPLY YES.
  - else i++ and cnt=0.
- REPLY: tx_valid=1 with tx_data held stable until handshake. On handshake, attempt_count increments (saturating).
  - YES: set unlocked, go to IDLE.
  - NO: go to WAIT_START.

Rules:
- rx bytes arriving in COMPARE, REPLY or ANNOUNCE are discarded and pulse rx_drop.
- In IDLE, rx bytes are ignored with no drop pulse.
- arm outside IDLE is ignored.
- The secret register is never updated mid-session.

## Timing
- Reset (async assert, synchronous deassert internally) values: state IDLE, tx_valid=0, tx_data=0x00, busy=0, unlocked=0, attempt_count=0, rx_drop=0, idx/i/cnt=0.
- Reset mid-operation aborts immediately: any in-flight tx byte is withdrawn and no reply is sent.
- Accepted arm at cycle t: tx_valid (0x02) is high at t+1.
- END accepted at cycle t: COMPARE is active at t+1. With first mismatch at index k, tx_valid is high at t+1+(k+1)·CMP_CYCLES. With a full match, tx_valid is high at t+1+CODE_LEN·CMP_CYCLES.
- Framing error at cycle t: NO is valid at t+1.
- The reply delay is independent of tx_ready; tx_ready stalls only extend REPLY.
- tx_valid never drops without a handshake, except on reset.
- rx_valid coincident with the tx handshake in REPLY(NO): the byte is dropped, because the state is still REPLY that cycle.
- busy is registered and follows the state on the same cycle.

## Test plan
Bench config: CODE_LEN=4, CMP_CYCLES=4, secret = bytes 0x10,0x20,0x30,0x40 (byte 0 first), tx_ready tied high unless noted.
- Reset then arm → tx 0x02 one cycle after arm; busy=1; unlocked=0, attempt_count=0.
- Send 01,10,20,99,40,05 → NO exactly 1+3·4=13 cycles after END; attempt_count=1; state returns to WAIT_START.
- Send 01,10,20,30,40,05 → YES 17 cycles after END; unlocked=1; busy=0 next cycle; attempt_count=2. A following arm clears unlocked.
- Send 01,77,20,30,40,05 → NO after 5 cycles. Send 01,10,20,30,40,AA → NO 1 cycle after AA with no compare.
- Hold tx_ready low 10 cycles during NO and inject an rx byte then → tx_data stays 0x04; rx_drop pulses once; handshake occurs on the first tx_ready-high cycle.
- Deassert RST_N during COMPARE → tx_valid=0 and state IDLE immediately. A later arm and full correct guess → YES.
